// File: rtl/np_mm_sequencer_pkg.sv
// Shared definitions for the FFN matrix-multiply sequencer: default network
// dimensions, the FSM state encoding and a width helper.
package np_mm_sequencer_pkg;

  localparam int NUM_BUF_DEF = 2;
  localparam int DOT_LEN_DEF = 64;
  localparam int NUM_OUT_DEF = 16;
  localparam int RD_LAT_DEF  = 1;

  // Address/index width that never collapses to zero bits for degenerate sizes.
  function automatic int clog2_min1(input int val);
    return (val > 1) ? $clog2(val) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_WAIT_FRAME = 2'd0,
    ST_RUN        = 2'd1,
    ST_GAP        = 2'd2,
    ST_DRAIN      = 2'd3
  } state_t;

endpackage

// File: rtl/np_mm_delay_line.sv
// Fixed-depth shift register carrying the MAC enable, last-element tag and
// neuron index alongside the buffer/ROM read latency.
module np_mm_delay_line
  import np_mm_sequencer_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one stage per cycle; reset flushes every stage so no stale enable escapes.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/np_mm_sequencer.sv
// Non-pipelined FFN matrix-multiply sequencer. Walks feature and weight
// addresses per output neuron, inserts a one-cycle bubble between dot products
// so the MAC clears itself, flags the cycle holding each finished sum and
// rotates through the ping-pong feature buffers.
// Optional macro NP_MM_SEQ_PERF_EN adds frames_done / busy_cycles counters.
//
// state        | meaning
// WAIT_FRAME   | idle until the selected buffer reports a loaded frame
// RUN          | issuing element addresses k = 0..DOT_LEN-1 for one neuron
// GAP          | single bubble cycle; MAC sees en=0 and clears
// DRAIN        | let the last result leave the read/MAC pipeline, then release
module np_mm_sequencer
  import np_mm_sequencer_pkg::*;
#(
  parameter int NUM_BUF = NUM_BUF_DEF,
  parameter int DOT_LEN = DOT_LEN_DEF,
  parameter int NUM_OUT = NUM_OUT_DEF,
  parameter int RD_LAT  = RD_LAT_DEF,
  parameter int FA_W    = clog2_min1(DOT_LEN),
  parameter int WA_W    = clog2_min1(NUM_OUT * DOT_LEN),
  parameter int OI_W    = clog2_min1(NUM_OUT)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BUF-1:0] frame_rdy,
  output logic [NUM_BUF-1:0] reading_frame,
  output logic               frame_release,
  output logic [FA_W-1:0]    buf_addr,
  output logic [WA_W-1:0]    weight_addr,
  output logic               mac_en,
  output logic               sum_valid,
  output logic [OI_W-1:0]    out_idx,
  output logic               busy
`ifdef NP_MM_SEQ_PERF_EN
  ,
  output logic [15:0]        frames_done,
  output logic [31:0]        busy_cycles
`endif
);

  localparam int DR_W = clog2_min1(RD_LAT + 1);
  localparam logic [FA_W-1:0] K_LAST    = FA_W'(DOT_LEN - 1);
  localparam logic [OI_W-1:0] N_LAST    = OI_W'(NUM_OUT - 1);
  localparam logic [DR_W-1:0] DRAIN_LD  = DR_W'(RD_LAT);
  localparam int              PIPE_W    = 2 + OI_W;

  state_t            state, state_nxt;
  logic [FA_W-1:0]   k;
  logic [WA_W-1:0]   w_addr;
  logic [OI_W-1:0]   neuron;
  logic [DR_W-1:0]   drain_cnt;

  logic              addr_vld;
  logic              start_frame;
  logic              next_neuron;
  logic              enter_drain;
  logic              end_frame;
  logic              k_last;
  logic              n_last;

  logic [PIPE_W-1:0] pipe_in, pipe_out;
  logic              last_d;
  logic [OI_W-1:0]   idx_d;

  assign k_last      = (k == K_LAST);
  assign n_last      = (neuron == N_LAST);
  assign buf_addr    = k;
  assign weight_addr = w_addr;
  assign busy        = (state != ST_WAIT_FRAME);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_WAIT_FRAME;
    else       state <= state_nxt;
  end

  // Next-state decode and the per-transition strobes used by the datapath.
  always_comb begin
    state_nxt   = state;
    addr_vld    = 1'b0;
    start_frame = 1'b0;
    next_neuron = 1'b0;
    enter_drain = 1'b0;
    end_frame   = 1'b0;
    case (state)
      ST_WAIT_FRAME: begin
        if (|(frame_rdy & reading_frame)) begin
          state_nxt   = ST_RUN;
          start_frame = 1'b1;
        end
      end
      ST_RUN: begin
        addr_vld = 1'b1;
        if (k_last) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (n_last) begin
          state_nxt   = ST_DRAIN;
          enter_drain = 1'b1;
        end else begin
          state_nxt   = ST_RUN;
          next_neuron = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == '0) begin
          state_nxt = ST_WAIT_FRAME;
          end_frame = 1'b1;
        end
      end
      default: state_nxt = ST_WAIT_FRAME;
    endcase
  end

  // Address counters, neuron index, drain timer and buffer rotation.
  // Addresses only move while issuing, so they hold through GAP/DRAIN/WAIT.
  // The weight address just keeps counting across the bubble: the last element
  // of neuron n plus one is the first element of neuron n+1.
  always_ff @(posedge clock) begin
    if (reset) begin
      k             <= '0;
      w_addr        <= '0;
      neuron        <= '0;
      drain_cnt     <= '0;
      reading_frame <= NUM_BUF'(1);
      frame_release <= 1'b0;
    end else begin
      frame_release <= end_frame;

      if (start_frame) begin
        k      <= '0;
        w_addr <= '0;
      end else if (next_neuron) begin
        k      <= '0;
        w_addr <= w_addr + WA_W'(1);
        neuron <= neuron + OI_W'(1);
      end else if (addr_vld && !k_last) begin
        k      <= k + FA_W'(1);
        w_addr <= w_addr + WA_W'(1);
      end

      if (enter_drain)
        drain_cnt <= DRAIN_LD;
      else if (state == ST_DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - DR_W'(1);

      if (end_frame) begin
        neuron        <= '0;
        reading_frame <= {reading_frame[NUM_BUF-2:0], reading_frame[NUM_BUF-1]};
      end
    end
  end

  assign pipe_in = {addr_vld, addr_vld & k_last, neuron};

  np_mm_delay_line #(
    .WIDTH (PIPE_W),
    .DEPTH (RD_LAT)
  ) u_rd_pipe (
    .clock (clock),
    .reset (reset),
    .din   (pipe_in),
    .dout  (pipe_out)
  );

  assign {mac_en, last_d, idx_d} = pipe_out;

  // One more stage past the MAC enable: the sum register holds the finished
  // dot product the cycle after the last enabled accumulate.
  always_ff @(posedge clock) begin
    if (reset) begin
      sum_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      sum_valid <= last_d;
      if (last_d) out_idx <= idx_d;
    end
  end

`ifdef NP_MM_SEQ_PERF_EN
  // Frame counter wraps; busy-cycle counter saturates.
  always_ff @(posedge clock) begin
    if (reset) begin
      frames_done <= '0;
      busy_cycles <= '0;
    end else begin
      if (end_frame) frames_done <= frames_done + 16'd1;
      if (busy && busy_cycles != 32'hFFFF_FFFF) busy_cycles <= busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_np_mm_sequencer.sv
// Scoreboard bench for np_mm_sequencer with DOT_LEN=4, NUM_OUT=2, NUM_BUF=2,
// RD_LAT=1 and a behavioural one-cycle-latency buffer/ROM plus MAC model.
module tb_np_mm_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] frame_rdy = 2'b00;
  logic [1:0] reading_frame;
  logic       frame_release;
  logic [1:0] buf_addr;
  logic [2:0] weight_addr;
  logic       mac_en;
  logic       sum_valid;
  logic [0:0] out_idx;
  logic       busy;
`ifdef NP_MM_SEQ_PERF_EN
  logic [15:0] frames_done;
  logic [31:0] busy_cycles;
`endif

  always #5 clk = ~clk;

  np_mm_sequencer #(
    .NUM_BUF (2),
    .DOT_LEN (4),
    .NUM_OUT (2),
    .RD_LAT  (1)
  ) dut (
    .clock         (clk),
    .reset         (reset),
    .frame_rdy     (frame_rdy),
    .reading_frame (reading_frame),
    .frame_release (frame_release),
    .buf_addr      (buf_addr),
    .weight_addr   (weight_addr),
    .mac_en        (mac_en),
    .sum_valid     (sum_valid),
    .out_idx       (out_idx),
    .busy          (busy)
`ifdef NP_MM_SEQ_PERF_EN
    ,
    .frames_done   (frames_done),
    .busy_cycles   (busy_cycles)
`endif
  );

  // Behavioural memories and MAC: read data returns one cycle after the address,
  // the accumulator adds while en=1 and clears on any en=0 cycle.
  logic [7:0]  fmem [2][4];
  logic [7:0]  wmem [8];
  logic [7:0]  f_q = 8'd0, w_q = 8'd0;
  logic [15:0] acc = 16'd0;

  always @(posedge clk) begin
    f_q <= fmem[reading_frame[1]][buf_addr];
    w_q <= wmem[weight_addr];
    if (mac_en) acc <= acc + 16'(f_q) * 16'(w_q);
    else        acc <= 16'd0;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int idx;
    int sum;
  } exp_t;

  exp_t       sq[$];
  logic [1:0] rq[$];

  // Monitor: pops an expected result on every sum_valid and an expected buffer
  // selection on every frame_release.
  int cyc = 0;
  int last_sv = 0;
  initial begin
    exp_t e;
    logic [1:0] r;
    forever begin
      @(negedge clk);
      cyc++;
      if (sum_valid) begin
        if (sq.size() == 0) begin
          chk("unexpected sum_valid", 32'd1, 32'd0);
        end else begin
          e = sq.pop_front();
          chk("out_idx", 32'(out_idx), 32'(e.idx));
          chk("mac sum", 32'(acc), 32'(e.sum));
          if (e.idx == 1) chk("sum_valid spacing", 32'(cyc - last_sv), 32'd5);
        end
        last_sv = cyc;
      end
      if (frame_release) begin
        if (rq.size() == 0) begin
          chk("unexpected frame_release", 32'd1, 32'd0);
        end else begin
          r = rq.pop_front();
          chk("reading_frame after release", 32'(reading_frame), 32'(r));
        end
      end
    end
  end

  task automatic push_frame(input int s0, input int s1, input logic [1:0] next_rf);
    exp_t e;
    e.idx = 0; e.sum = s0; sq.push_back(e);
    e.idx = 1; e.sum = s1; sq.push_back(e);
    rq.push_back(next_rf);
  endtask

  task automatic wait_release(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (frame_release) seen = 1'b1;
    end
    if (!seen) chk("frame_release timeout", 32'd0, 32'd1);
  endtask

  // First-frame per-cycle expectations, from the first RUN cycle to the release cycle.
  int exp_ba   [13] = '{0, 1, 2, 3, 3, 0, 1, 2, 3, 3, 3, 3, 3};
  int exp_wa   [13] = '{0, 1, 2, 3, 3, 4, 5, 6, 7, 7, 7, 7, 7};
  int exp_en   [13] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0};
  int exp_busy [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 4; i++) fmem[b][i] = 8'd1;
    for (int i = 0; i < 8; i++) wmem[i] = 8'd1;

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset with nothing ready.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle {rf,en,sv,busy,rel}", {reading_frame, mac_en, sum_valid, busy, frame_release}, 6'b01_0000);
    end
    chk("reset buf_addr", 32'(buf_addr), 32'd0);
    chk("reset weight_addr", 32'(weight_addr), 32'd0);
    chk("reset out_idx", 32'(out_idx), 32'd0);

    // Frame 1: all-ones features and weights, addresses and enables cycle by cycle.
    push_frame(4, 4, 2'b10);
    frame_rdy = 2'b01;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      chk("frame1 buf_addr", 32'(buf_addr), 32'(exp_ba[i]));
      chk("frame1 weight_addr", 32'(weight_addr), 32'(exp_wa[i]));
      chk("frame1 mac_en", 32'(mac_en), 32'(exp_en[i]));
      chk("frame1 busy", 32'(busy), 32'(exp_busy[i]));
    end

    // Only buffer 0 ready: sequencer must idle on buffer 1.
    wmem = '{8'd1, 8'd0, 8'd2, 8'd1, 8'd3, 8'd1, 8'd0, 8'd2};
    fmem[1] = '{8'd1, 8'd2, 8'd3, 8'd4};
    fmem[0] = '{8'd2, 8'd1, 8'd1, 8'd5};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wait buf1 {rf,busy}", {reading_frame, busy}, 3'b10_0);
    end

    // Frame 2 on buffer 1: sums 1+0+6+4=11 and 3+2+0+8=13.
    push_frame(11, 13, 2'b01);
    frame_rdy = 2'b10;
    @(negedge clk);
    chk("frame2 start busy", 32'(busy), 32'd1);
    chk("frame2 start buf_addr", 32'(buf_addr), 32'd0);
    chk("frame2 start weight_addr", 32'(weight_addr), 32'd0);
    wait_release(30);

    // Back-to-back frames: buffer 0 sums 2+0+2+5=9 and 6+1+0+10=17.
    push_frame(9, 17, 2'b10);
    push_frame(11, 13, 2'b01);
    push_frame(9, 17, 2'b10);
    frame_rdy = 2'b11;
    wait_release(30);
    wait_release(30);
    wait_release(30);
    frame_rdy = 2'b00;

    // Reset during the second neuron of a buffer-1 frame: only neuron 0 completes.
    begin
      exp_t e;
      e.idx = 0; e.sum = 11; sq.push_back(e);
    end
    frame_rdy = 2'b10;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid reset reading_frame", 32'(reading_frame), 32'd1);
    chk("mid reset {en,sv,busy,rel}", {mac_en, sum_valid, busy, frame_release}, 4'b0000);
    chk("mid reset buf_addr", 32'(buf_addr), 32'd0);
    chk("mid reset weight_addr", 32'(weight_addr), 32'd0);
    chk("mid reset out_idx", 32'(out_idx), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post reset busy", 32'(busy), 32'd0);

    // Following frame on buffer 0 must produce clean sums.
    push_frame(9, 17, 2'b10);
    frame_rdy = 2'b01;
    wait_release(30);
    frame_rdy = 2'b00;

`ifdef NP_MM_SEQ_PERF_EN
    chk("frames_done", 32'(frames_done), 32'd1);
    chk("busy_cycles", busy_cycles, 32'd12);
`endif

    repeat (5) @(negedge clk);
    chk("pending sums", 32'(sq.size()), 32'd0);
    chk("pending releases", 32'(rq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
